// File: rtl/input_matrix_control_unit_pkg.sv
// Shared definitions for the input matrix control unit: default widths and
// the controller state encoding.
package input_matrix_control_unit_pkg;

   localparam int DEF_DIMM_BUS_WIDTH = 16;
   localparam int DEF_PIX_WIDTH      = 8;
   localparam int DEF_ADDR_WIDTH     = 32;
   localparam int WIN_DIM            = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READY = 3'd1,
      FETCH = 3'd2,
      DRAIN = 3'd3,
      ACK   = 3'd4
   } state_t;

   typedef logic [1:0] phase_t;

endpackage

// File: rtl/input_matrix_control_unit_if.sv
// Control, frame-memory and window signals of the input matrix control unit,
// bundled with a slave view for the block and a master view for its driver.
interface input_matrix_control_unit_if
   import input_matrix_control_unit_pkg::*;
#(
   parameter int DIMM_BUS_WIDTH = DEF_DIMM_BUS_WIDTH,
   parameter int PIX_WIDTH      = DEF_PIX_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
);
   logic [DIMM_BUS_WIDTH-1:0] frame_input_width;
   logic [DIMM_BUS_WIDTH-1:0] frame_input_height;
   logic                      start;
   logic                      req_pix;
   logic                      new_line;
   logic                      pix_ctrl_ack;
   logic                      busy;
   logic                      rd_en;
   logic [ADDR_WIDTH-1:0]     rd_addr;
   logic [PIX_WIDTH-1:0]      rd_data;
   logic [9*PIX_WIDTH-1:0]    window;

   modport slave (
      input  frame_input_width, frame_input_height, start, req_pix, new_line, rd_data,
      output pix_ctrl_ack, busy, rd_en, rd_addr, window
   );

   modport master (
      output frame_input_width, frame_input_height, start, req_pix, new_line, rd_data,
      input  pix_ctrl_ack, busy, rd_en, rd_addr, window
   );
endinterface

// File: rtl/input_matrix_control_unit_window_shift_reg_3x3.sv
// 3x3 pixel window held as three columns: fill copies one column into all
// three, shift moves columns left and appends the new column on the right.
module window_shift_reg_3x3
   import input_matrix_control_unit_pkg::*;
#(
   parameter int PIX_WIDTH = DEF_PIX_WIDTH
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         shift_en,
   input  logic                         fill_en,
   input  logic [WIN_DIM*PIX_WIDTH-1:0] col_in,
   output logic [9*PIX_WIDTH-1:0]       window
);

   genvar gi, gc;
   generate
      for (gi = 0; gi < WIN_DIM; gi++) begin : g_row
         logic [PIX_WIDTH-1:0] cell_reg [WIN_DIM];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int c = 0; c < WIN_DIM; c++) cell_reg[c] <= '0;
            end else if (fill_en) begin
               for (int c = 0; c < WIN_DIM; c++) cell_reg[c] <= col_in[gi*PIX_WIDTH +: PIX_WIDTH];
            end else if (shift_en) begin
               cell_reg[0] <= cell_reg[1];
               cell_reg[1] <= cell_reg[2];
               cell_reg[2] <= col_in[gi*PIX_WIDTH +: PIX_WIDTH];
            end
         end

         for (gc = 0; gc < WIN_DIM; gc++) begin : g_col
            assign window[(gi*WIN_DIM+gc)*PIX_WIDTH +: PIX_WIDTH] = cell_reg[gc];
         end
      end
   endgenerate

endmodule

// File: rtl/input_matrix_control_unit.sv
// Fetches 3-pixel columns from external frame memory on request and shifts
// them into a 3x3 window, replicating edge pixels at the frame borders.
module input_matrix_control_unit
   import input_matrix_control_unit_pkg::*;
#(
   parameter int DIMM_BUS_WIDTH = DEF_DIMM_BUS_WIDTH,
   parameter int PIX_WIDTH      = DEF_PIX_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
)(
   input logic                        clk,
   input logic                        reset,
   input_matrix_control_unit_if.slave bus
);

   localparam logic [DIMM_BUS_WIDTH-1:0] DIM_ONE = DIMM_BUS_WIDTH'(1);
   localparam logic [DIMM_BUS_WIDTH:0]   DIM_TWO = (DIMM_BUS_WIDTH+1)'(2);

   state_t                    state_reg, state_next;
   logic [DIMM_BUS_WIDTH-1:0] width_reg, height_reg;
   logic [DIMM_BUS_WIDTH-1:0] y_reg;
   logic                      y_valid_reg;
   logic [DIMM_BUS_WIDTH-1:0] col_next_reg;
   logic [ADDR_WIDTH-1:0]     base_top_reg, base_mid_reg, base_bot_reg;
   phase_t                    phase_reg;
   logic                      more_cols_reg;
   logic                      line_fill_reg;
   logic                      cap_valid_reg;
   phase_t                    cap_phase_reg;
   logic                      cap_fill_reg;
   logic [PIX_WIDTH-1:0]      buf_top_reg, buf_mid_reg;

   logic                      dims_ok;
   logic                      at_last_row;
   logic                      accept_line;
   logic                      accept_plain;
   logic [DIMM_BUS_WIDTH:0]   y_plus2;
   logic [DIMM_BUS_WIDTH-1:0] col_clamp;
   logic [ADDR_WIDTH-1:0]     row_base;
   logic [ADDR_WIDTH-1:0]     width_ext;
   logic                      col_done;
   logic                      shift_en;
   logic                      fill_en;

   assign width_ext   = ADDR_WIDTH'(width_reg);
   assign dims_ok     = (width_reg != '0) && (height_reg != '0);
   assign at_last_row = y_valid_reg && (y_reg == height_reg - DIM_ONE);
   assign accept_line  = (state_reg == READY) && bus.req_pix && bus.new_line
                         && dims_ok && !at_last_row;
   assign accept_plain = (state_reg == READY) && bus.req_pix && !bus.new_line
                         && dims_ok && y_valid_reg;
   assign y_plus2     = {1'b0, y_reg} + DIM_TWO;
   assign col_clamp   = (col_next_reg < width_reg) ? col_next_reg
                      : (width_reg == '0) ? '0 : width_reg - DIM_ONE;

   always_comb begin
      row_base = base_top_reg;
      case (phase_reg)
         2'd1:    row_base = base_mid_reg;
         2'd2:    row_base = base_bot_reg;
         default: row_base = base_top_reg;
      endcase
   end

   assign bus.rd_en        = (state_reg == FETCH);
   assign bus.rd_addr      = bus.rd_en ? row_base + ADDR_WIDTH'(col_clamp) : '0;
   assign bus.busy         = (state_reg == FETCH) || (state_reg == DRAIN) || (state_reg == ACK);
   assign bus.pix_ctrl_ack = (state_reg == ACK);

   // Third read of a column lands one cycle late; that is when the column
   // is complete and enters the window.
   assign col_done = cap_valid_reg && (cap_phase_reg == 2'd2) && !bus.start;
   assign fill_en  = col_done && cap_fill_reg;
   assign shift_en = col_done && !cap_fill_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (bus.start) begin
         state_next = READY;
      end else begin
         case (state_reg)
            IDLE:    state_next = IDLE;
            READY:   if (accept_line || accept_plain) state_next = FETCH;
            FETCH:   if (phase_reg == 2'd2 && !more_cols_reg) state_next = DRAIN;
            DRAIN:   state_next = ACK;
            ACK:     state_next = READY;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         width_reg     <= '0;
         height_reg    <= '0;
         y_reg         <= '0;
         y_valid_reg   <= 1'b0;
         col_next_reg  <= '0;
         base_top_reg  <= '0;
         base_mid_reg  <= '0;
         base_bot_reg  <= '0;
         phase_reg     <= '0;
         more_cols_reg <= 1'b0;
         line_fill_reg <= 1'b0;
         cap_valid_reg <= 1'b0;
         cap_phase_reg <= '0;
         cap_fill_reg  <= 1'b0;
         buf_top_reg   <= '0;
         buf_mid_reg   <= '0;
      end else if (bus.start) begin
         width_reg     <= bus.frame_input_width;
         height_reg    <= bus.frame_input_height;
         y_reg         <= '0;
         y_valid_reg   <= 1'b0;
         col_next_reg  <= '0;
         base_top_reg  <= '0;
         base_mid_reg  <= '0;
         base_bot_reg  <= '0;
         phase_reg     <= '0;
         more_cols_reg <= 1'b0;
         line_fill_reg <= 1'b0;
         cap_valid_reg <= 1'b0;
         cap_fill_reg  <= 1'b0;
      end else begin
         if (accept_line) begin
            y_valid_reg   <= 1'b1;
            col_next_reg  <= '0;
            phase_reg     <= '0;
            more_cols_reg <= 1'b1;
            line_fill_reg <= 1'b1;
            if (!y_valid_reg) begin
               y_reg        <= '0;
               base_top_reg <= '0;
               base_mid_reg <= '0;
               base_bot_reg <= (height_reg > DIM_ONE) ? width_ext : '0;
            end else begin
               // Row bases slide down one row; the bottom stops advancing at the last row.
               y_reg        <= y_reg + DIM_ONE;
               base_top_reg <= base_mid_reg;
               base_mid_reg <= base_bot_reg;
               base_bot_reg <= (y_plus2 < {1'b0, height_reg}) ? base_bot_reg + width_ext
                                                               : base_bot_reg;
            end
         end else if (accept_plain) begin
            phase_reg     <= '0;
            more_cols_reg <= 1'b0;
            line_fill_reg <= 1'b0;
         end

         if (state_reg == FETCH) begin
            phase_reg <= (phase_reg == 2'd2) ? 2'd0 : phase_reg + 2'd1;
            if (phase_reg == 2'd2) begin
               more_cols_reg <= 1'b0;
               line_fill_reg <= 1'b0;
               if (col_next_reg < width_reg) col_next_reg <= col_next_reg + DIM_ONE;
            end
         end

         cap_valid_reg <= (state_reg == FETCH);
         cap_phase_reg <= phase_reg;
         cap_fill_reg  <= line_fill_reg;
         if (cap_valid_reg && cap_phase_reg == 2'd0) buf_top_reg <= bus.rd_data;
         if (cap_valid_reg && cap_phase_reg == 2'd1) buf_mid_reg <= bus.rd_data;
      end
   end

   window_shift_reg_3x3 #(
      .PIX_WIDTH (PIX_WIDTH)
   ) u_window (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .fill_en  (fill_en),
      .col_in   ({bus.rd_data, buf_mid_reg, buf_top_reg}),
      .window   (bus.window)
   );

endmodule

// File: tb/tb_input_matrix_control_unit.sv
// Directed bench: 4x3 frame with pix = 16*row+col served by a one-cycle
// latency memory model; checks latency, read counts, windows and aborts.
module tb_input_matrix_control_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   check_cnt = 0;
   int   pass_cnt = 0;
   int   mem_w = 0;
   int   acks, rds, lat;
   logic busy1, busy_after;

   always #5 clk = ~clk;

   input_matrix_control_unit_if bus ();

   input_matrix_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(posedge clk) begin
      if (bus.rd_en && mem_w != 0)
         bus.rd_data <= 8'(16 * (int'(bus.rd_addr) / mem_w) + (int'(bus.rd_addr) % mem_w));
      else
         bus.rd_data <= 8'h0;
   end

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [71:0] win9(input int t0, t1, t2, m0, m1, m2, b0, b1, b2);
      return {b2[7:0], b1[7:0], b0[7:0], m2[7:0], m1[7:0], m0[7:0], t2[7:0], t1[7:0], t0[7:0]};
   endfunction

   task automatic do_start(input int w, input int h, input logic with_req);
      @(negedge clk);
      bus.frame_input_width  = 16'(w);
      bus.frame_input_height = 16'(h);
      bus.start    = 1'b1;
      bus.req_pix  = with_req;
      bus.new_line = with_req;
      mem_w = w;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.req_pix  = 1'b0;
      bus.new_line = 1'b0;
   endtask

   // Pulses req_pix, optionally again at cycle 'repulse', and observes a fixed span.
   task automatic run_req(input logic nl, input int repulse, input int span);
      acks = 0; rds = 0; lat = 0; busy1 = 1'b0; busy_after = 1'b1;
      @(negedge clk);
      bus.req_pix  = 1'b1;
      bus.new_line = nl;
      for (int c = 1; c <= span; c++) begin
         @(negedge clk);
         bus.req_pix  = (c == repulse);
         bus.new_line = (c == repulse) ? nl : 1'b0;
         if (bus.pix_ctrl_ack) begin
            acks++;
            if (lat == 0) lat = c;
         end
         if (bus.rd_en) rds++;
         if (c == 1) busy1 = bus.busy;
         if (lat != 0 && c == lat + 1) busy_after = bus.busy;
      end
      $display("req new_line=%0b: acks=%0d latency=%0d reads=%0d window=%0h", nl, acks, lat, rds, bus.window);
   endtask

   initial begin
      bus.frame_input_width  = '0;
      bus.frame_input_height = '0;
      bus.start    = 1'b0;
      bus.req_pix  = 1'b0;
      bus.new_line = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ack", bus.pix_ctrl_ack, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_rd_addr", bus.rd_addr, 0);
      check("rst_window", bus.window, 0);

      run_req(1'b1, 0, 14);
      check("idle_ignored", acks, 0);

      do_start(4, 3, 1'b0);
      run_req(1'b1, 0, 14);
      check("nl0_lat", lat, 8);
      check("nl0_reads", rds, 6);
      check("nl0_busy_rise", busy1, 1);
      check("nl0_busy_fall", busy_after, 0);
      check("nl0_window", bus.window, win9(0, 0, 1, 0, 0, 1, 16, 16, 17));

      for (int i = 0; i < 3; i++) begin
         run_req(1'b0, 0, 12);
         check("plain_lat", lat, 5);
         check("plain_reads", rds, 3);
      end
      check("plain_window", bus.window, win9(2, 3, 3, 2, 3, 3, 18, 19, 19));

      run_req(1'b1, 0, 14);
      check("nl1_lat", lat, 8);
      run_req(1'b1, 0, 14);
      check("nl2_lat", lat, 8);
      check("nl2_window", bus.window, win9(16, 16, 17, 32, 32, 33, 32, 32, 33));
      run_req(1'b1, 0, 14);
      check("exhausted_acks", acks, 0);
      check("exhausted_reads", rds, 0);

      run_req(1'b0, 2, 14);
      check("fetch_req_acks", acks, 1);
      check("fetch_req_lat", lat, 5);

      do_start(4, 3, 1'b1);
      check("start_req_reads", bus.rd_en, 0);
      run_req(1'b0, 0, 12);
      check("start_req_plain_ign", acks, 0);
      check("start_req_plain_rds", rds, 0);
      run_req(1'b1, 0, 14);
      check("start_req_nl_lat", lat, 8);
      check("start_req_nl_window", bus.window, win9(0, 0, 1, 0, 0, 1, 16, 16, 17));

      @(negedge clk);
      bus.req_pix = 1'b1;
      @(negedge clk);
      bus.req_pix = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_rd_en", bus.rd_en, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_ack", bus.pix_ctrl_ack, 0);
      check("abort_rd_addr", bus.rd_addr, 0);
      check("abort_window", bus.window, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      acks = 0; rds = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.pix_ctrl_ack) acks++;
         if (bus.rd_en) rds++;
      end
      $display("after abort: acks=%0d reads=%0d", acks, rds);
      check("abort_no_ack", acks, 0);
      check("abort_no_reads", rds, 0);

      do_start(1, 3, 1'b0);
      run_req(1'b1, 0, 14);
      check("w1_lat", lat, 8);
      check("w1_window", bus.window, win9(0, 0, 0, 0, 0, 0, 16, 16, 16));

      do_start(0, 3, 1'b0);
      run_req(1'b1, 0, 14);
      check("w0_acks", acks, 0);
      check("w0_reads", rds, 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/input_matrix_control_unit.md
INPUT_MATRIX_CONTROL_UNIT -- requirements
Module: input_matrix_control_unit

Interface
REQ-001 Parameter DIMM_BUS_WIDTH, default 16, frame dimension width in bits.
REQ-002 Parameter PIX_WIDTH, default 8, pixel width in bits.
REQ-003 Parameter ADDR_WIDTH, default 32, frame memory address width.
REQ-004 clk  in  1  single clock for all state, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 frame_input_width  in  DIMM_BUS_WIDTH  frame width in pixels, sampled on start.
REQ-007 frame_input_height  in  DIMM_BUS_WIDTH  frame height in pixels, sampled on start.
REQ-008 start  in  1  single-cycle pulse; latches dimensions and arms the block.
REQ-009 req_pix  in  1  single-cycle pulse from the filtering control unit requesting the next window column.
REQ-010 new_line  in  1  qualifies req_pix; when high, the request starts the next output row.
REQ-011 pix_ctrl_ack  out  1  single-cycle pulse; the window holds the requested data.
REQ-012 busy  out  1  high while a request is being serviced.
REQ-013 rd_en  out  1  frame memory read strobe.
REQ-014 rd_addr  out  ADDR_WIDTH  frame memory read address, row*width+col.
REQ-015 rd_data  in  PIX_WIDTH  read data, valid exactly one cycle after rd_en.
REQ-016 window  out  9*PIX_WIDTH  3x3 window, row-major, [PIX_WIDTH-1:0] = top-left.

Function
REQ-017 States: IDLE, READY, FETCH, DRAIN, ACK; only the states named here exist.
REQ-018 IDLE: req_pix is ignored; start moves to READY and sets row y = -1 (none) and col_next = 0.
REQ-019 READY: req_pix moves to FETCH; busy rises the next cycle and stays high until the cycle after pix_ctrl_ack.
REQ-020 Column fetch: 3 consecutive rd_en cycles at rows clamp(y-1), y, clamp(y+1), column clamp(col_next). Clamp is to [0, height-1] for rows and [0, width-1] for columns (edge replication).
REQ-021 DRAIN: captures the final read data; the window shifts left by one column and the new column enters on the right.
REQ-022 Plain request: exactly one column fetch, then col_next increments. Latency is 5 cycles from req_pix to pix_ctrl_ack.
REQ-023 new_line request: y increments first, then col_next resets to 0 and two column fetches run back-to-back (6 rd_en cycles).
REQ-024 After a new_line request, the window columns are {c0, c0, c1}, with c1 clamped to c0 when width = 1. Latency is 8 cycles to ack; col_next ends at 2.
REQ-025 ACK: pix_ctrl_ack is high for one cycle, then the state returns to READY.
REQ-026 req_pix outside READY is ignored; no queuing.
REQ-027 new_line request when y = height-1 (frame exhausted): ignored, no reads, no ack, state stays READY.
REQ-028 Plain request while y = -1: ignored.
REQ-029 start in any state overrides everything, including a simultaneous req_pix. It relatches the dimensions and goes to READY. An in-flight fetch is discarded and no ack is issued.
REQ-030 Address arithmetic: ADDR_WIDTH unsigned. Row base is held as an accumulated register (+width per row), with no multiplier.
REQ-031 width = 0 or height = 0 is latched as-is; every subsequent request is ignored.

Reset
REQ-032 Reset values: state IDLE, pix_ctrl_ack = 0, busy = 0, rd_en = 0, rd_addr = 0, window = 0, all counters 0.
REQ-033 Reset asserted mid-fetch aborts immediately. No ack follows deassertion.

Structure
REQ-034 Shared package holds DIMM_BUS_WIDTH, PIX_WIDTH, ADDR_WIDTH defaults and the state encoding.
REQ-035 One sub-module, window_shift_reg_3x3: shift-on-enable column register with column load input.
REQ-036 No memories inside the block; frame memory is external.

Verification
REQ-037 Frame 4x3 with pix = 16*row+col; start, then req_pix+new_line -> ack at cycle +8; window = {0,0,1 / 0,0,1 / 16,16,17}.
REQ-038 Then 3 plain req_pix -> each acks at +5; the last window is {2,3,3 / 2,3,3 / 18,19,19}.
REQ-039 Advance to row 2, then new_line -> bottom row replicated: window = {16,16,17 / 32,32,33 / 32,32,33}. A further new_line -> no ack, rd_en stays 0.
REQ-040 req_pix pulsed during FETCH -> ignored; exactly one ack results.
REQ-041 start coincident with req_pix in READY -> no reads; state READY; y = -1.
REQ-042 reset asserted 2 cycles into a fetch -> all outputs 0 asynchronously; no ack after release.
